// File: rtl/dp_jtag_master.sv
// JTAG scan master: turns one-word scan commands into TCK/TMS/TDI waveforms and
// collects TDO, tracking the remote TAP so it always parks in Run-Test/Idle.
module dp_jtag_master #(
  parameter int DIV     = 2,
  parameter int MAX_LEN = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [5:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo,
  output logic               busy,
  output logic [3:0]         state_out
);
  // Handshake: a command transfers on the clk edge where cmd_valid && cmd_ready;
  // cmd_ready stays low until the rsp_valid cycle, and responses are never stalled.
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [1:0] OP_RST = 2'd0, OP_IR = 2'd1, OP_DR = 2'd2;

  typedef enum logic [3:0] {
    TLR = 4'hF, RTI = 4'hC, SDR = 4'h7, CDR = 4'h6, SHD = 4'h2, E1D = 4'h1,
    PDR = 4'h3, E2D = 4'h0, UDR = 4'h5, SIR = 4'h4, CIR = 4'hE, SHI = 4'hA,
    E1I = 4'h9, PIR = 4'hB, E2I = 4'h8, UIR = 4'hD
  } tap_t;

  typedef struct packed {
    logic          tms;
    logic          shift;
    logic [IW-1:0] idx;
  } ctl_t;

  function automatic tap_t tap_next(input tap_t s, input logic t);
    case (s)
      TLR:     tap_next = t ? TLR : RTI;
      RTI:     tap_next = t ? SDR : RTI;
      SDR:     tap_next = t ? SIR : CDR;
      CDR:     tap_next = t ? E1D : SHD;
      SHD:     tap_next = t ? E1D : SHD;
      E1D:     tap_next = t ? UDR : PDR;
      PDR:     tap_next = t ? E2D : PDR;
      E2D:     tap_next = t ? UDR : SHD;
      UDR:     tap_next = t ? SDR : RTI;
      SIR:     tap_next = t ? TLR : CIR;
      CIR:     tap_next = t ? E1I : SHI;
      SHI:     tap_next = t ? E1I : SHI;
      E1I:     tap_next = t ? UIR : PIR;
      PIR:     tap_next = t ? E2I : PIR;
      E2I:     tap_next = t ? UIR : SHI;
      UIR:     tap_next = t ? SDR : RTI;
      default: tap_next = TLR;
    endcase
  endfunction

  // TMS and shift position for tick j; pre inserts a leading TLR->RTI tick.
  function automatic ctl_t tick_ctl(input logic [1:0] op, input logic [6:0] n,
                                    input logic pre, input logic [6:0] j);
    logic [6:0] k;
    logic [6:0] s0;
    tick_ctl = '0;
    k  = j - {6'd0, pre};
    s0 = (op == OP_IR) ? 7'd4 : 7'd3;
    if (!(pre && j == 7'd0)) begin
      case (op)
        OP_RST: tick_ctl.tms = (j < 7'd5);
        OP_IR, OP_DR: begin
          if (k < s0) begin
            tick_ctl.tms = (op == OP_IR) ? (k < 7'd2) : (k == 7'd0);
          end else if (k < s0 + n) begin
            tick_ctl.shift = 1'b1;
            tick_ctl.idx   = IW'(k - s0);
            tick_ctl.tms   = ((k - s0) == (n - 7'd1));
          end else begin
            tick_ctl.tms = (k == s0 + n);
          end
        end
        default: tick_ctl.tms = 1'b0;
      endcase
    end
  endfunction

  function automatic logic [6:0] t_total(input logic [1:0] op, input logic [6:0] n,
                                         input logic pre);
    case (op)
      OP_RST:  t_total = 7'd6;
      OP_IR:   t_total = n + 7'd6 + {6'd0, pre};
      OP_DR:   t_total = n + 7'd5 + {6'd0, pre};
      default: t_total = n + {6'd0, pre};
    endcase
  endfunction

  tap_t               tap;
  logic [1:0]         op_q;
  logic [6:0]         n_q, j_q, total_q;
  logic               pre_q;
  logic [MAX_LEN-1:0] data_q, cap_q, cap_nx;
  logic [DW-1:0]      div_cnt;
  logic [6:0]         len_eff;
  logic               pre_in;
  ctl_t               ctl0, ctl_cur, ctl_nx;

  assign state_out = tap;

  always_comb begin
    len_eff = {1'b0, cmd_len};
    if (cmd_len == 6'd0 || {1'b0, cmd_len} > 7'(MAX_LEN)) len_eff = 7'(MAX_LEN);
    pre_in  = (tap == TLR) && (cmd_op != OP_RST);
    ctl0    = tick_ctl(cmd_op, len_eff, pre_in, 7'd0);
    ctl_cur = tick_ctl(op_q, n_q, pre_q, j_q);
    ctl_nx  = tick_ctl(op_q, n_q, pre_q, j_q + 7'd1);
    cap_nx  = cap_q;
    if (ctl_cur.shift) cap_nx[ctl_cur.idx] = tdo;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tck       <= 1'b0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      tap       <= TLR;
      op_q      <= 2'd0;
      n_q       <= 7'd0;
      j_q       <= 7'd0;
      total_q   <= 7'd0;
      pre_q     <= 1'b0;
      data_q    <= '0;
      cap_q     <= '0;
      div_cnt   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (!busy) begin
        if (cmd_valid && cmd_ready) begin
          busy      <= 1'b1;
          cmd_ready <= 1'b0;
          op_q      <= cmd_op;
          n_q       <= len_eff;
          pre_q     <= pre_in;
          data_q    <= cmd_data;
          total_q   <= t_total(cmd_op, len_eff, pre_in);
          j_q       <= 7'd0;
          div_cnt   <= '0;
          tck       <= 1'b0;
          cap_q     <= '0;
          tms       <= ctl0.tms;
          tdi       <= ctl0.shift ? cmd_data[ctl0.idx] : 1'b0;
        end else begin
          cmd_ready <= 1'b1;
        end
      end else if (div_cnt != DW'(DIV - 1)) begin
        div_cnt <= div_cnt + 1'b1;
      end else begin
        div_cnt <= '0;
        if (!tck) begin
          tck <= 1'b1;
          tap <= tap_next(tap, tms);
        end else begin
          // Falling edge: tdo sampled here, then next tick's tms/tdi launched.
          tck   <= 1'b0;
          cap_q <= cap_nx;
          if (j_q == total_q - 7'd1) begin
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_data  <= cap_nx;
            tdi       <= 1'b0;
          end else begin
            j_q <= j_q + 7'd1;
            tms <= ctl_nx.tms;
            tdi <= ctl_nx.shift ? data_q[ctl_nx.idx] : 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_dp_jtag_master.sv
// Bench for dp_jtag_master: drives scan commands against a small behavioural DAP
// (5-bit IR, IDCODE and BYPASS) and scores response data, latency and TMS streams.
module tb_dp_jtag_master;
  localparam int DIV = 2;
  localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC;
  localparam logic [4:0] IR_IDCODE = 5'h01;
  localparam logic [31:0] IDCODE = 32'h1000_0802;
  localparam logic [63:0] TMS_IR5 = 64'b1100_00001_10;
  localparam logic [63:0] TMS_DR32 = {27'd0, 3'b100, 31'd0, 1'b1, 2'b10};
  localparam logic [63:0] TMS_DR20 = {39'd0, 3'b100, 19'd0, 1'b1, 2'b10};

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [5:0]  cmd_len = 6'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        tck, tms, tdi, busy;
  logic        tdo;
  logic [3:0]  state_out;

  dp_jtag_master #(.DIV(DIV), .MAX_LEN(32)) dut (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo), .busy(busy),
    .state_out(state_out)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // behavioural DAP, TRST tied to resetn
  typedef enum logic [3:0] {
    D_TLR = 4'hF, D_RTI = 4'hC, D_SDR = 4'h7, D_CDR = 4'h6, D_SHD = 4'h2, D_E1D = 4'h1,
    D_PDR = 4'h3, D_E2D = 4'h0, D_UDR = 4'h5, D_SIR = 4'h4, D_CIR = 4'hE, D_SHI = 4'hA,
    D_E1I = 4'h9, D_PIR = 4'hB, D_E2I = 4'h8, D_UIR = 4'hD
  } dst_t;

  function automatic dst_t dnext(input dst_t s, input logic t);
    case (s)
      D_TLR: dnext = t ? D_TLR : D_RTI;
      D_RTI: dnext = t ? D_SDR : D_RTI;
      D_SDR: dnext = t ? D_SIR : D_CDR;
      D_CDR: dnext = t ? D_E1D : D_SHD;
      D_SHD: dnext = t ? D_E1D : D_SHD;
      D_E1D: dnext = t ? D_UDR : D_PDR;
      D_PDR: dnext = t ? D_E2D : D_PDR;
      D_E2D: dnext = t ? D_UDR : D_SHD;
      D_UDR: dnext = t ? D_SDR : D_RTI;
      D_SIR: dnext = t ? D_TLR : D_CIR;
      D_CIR: dnext = t ? D_E1I : D_SHI;
      D_SHI: dnext = t ? D_E1I : D_SHI;
      D_E1I: dnext = t ? D_UIR : D_PIR;
      D_PIR: dnext = t ? D_E2I : D_PIR;
      D_E2I: dnext = t ? D_UIR : D_SHI;
      default: dnext = t ? D_SDR : D_RTI;
    endcase
  endfunction

  dst_t        d_st;
  logic [4:0]  ir, ir_sr;
  logic [31:0] dr_sr;
  logic        bp;

  always @(posedge tck or negedge resetn) begin
    if (!resetn) begin
      d_st <= D_TLR;
      ir   <= IR_IDCODE;
    end else begin
      case (d_st)
        D_TLR: ir <= IR_IDCODE;
        D_CIR: ir_sr <= 5'b00001;
        D_SHI: ir_sr <= {tdi, ir_sr[4:1]};
        D_UIR: ir <= ir_sr;
        D_CDR: begin dr_sr <= (ir == IR_IDCODE) ? IDCODE : 32'd0; bp <= 1'b0; end
        D_SHD: begin dr_sr <= {tdi, dr_sr[31:1]}; bp <= tdi; end
        default: ;
      endcase
      d_st <= dnext(d_st, tms);
    end
  end

  always @(negedge tck or negedge resetn) begin
    if (!resetn) tdo <= 1'b0;
    else if (d_st == D_SHI) tdo <= ir_sr[0];
    else if (d_st == D_SHD) tdo <= (ir == IR_IDCODE) ? dr_sr[0] : bp;
    else tdo <= 1'b0;
  end

  // tick monitor
  int          tick_cnt = 0;
  logic [63:0] tms_hist = '0;
  always @(posedge tck) begin
    tick_cnt = tick_cnt + 1;
    tms_hist = {tms_hist[62:0], tms};
  end

  // scoreboard
  logic [31:0] exp_q[$];
  int          tick_q[$];
  logic [63:0] tms_q[$];
  int          acc_q[$];
  int          last_acc_cyc = 0;
  int          last_rsp_cyc = 0;

  always @(negedge clk) begin
    if (resetn && rsp_valid === 1'b1) begin
      last_rsp_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        logic [31:0] e;
        logic [63:0] m, msk;
        int t, a;
        e = exp_q.pop_front();
        t = tick_q.pop_front();
        m = tms_q.pop_front();
        a = (acc_q.size() != 0) ? acc_q.pop_front() : 0;
        msk = (64'd1 << t) - 64'd1;
        check("rsp_data", rsp_data, e);
        check("latency", cyc - a, 2 * DIV * t);
        check("ticks", tick_cnt, t);
        check("tms_seq", tms_hist & msk, m);
        check("state_end", state_out, S_RTI);
        check("busy_end", busy, 0);
        check("ready_end", cmd_ready, 1);
      end
    end
  end

  // driver tasks (caller sits on a negedge)
  task automatic issue(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                       input logic expect_rsp, input logic hold, input logic [31:0] exp_data,
                       input int ticks, input logic [63:0] exp_tms);
    int b;
    b = 0;
    cmd_op = op; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
    if (expect_rsp) begin
      exp_q.push_back(exp_data);
      tick_q.push_back(ticks);
      tms_q.push_back(exp_tms);
    end
    while (cmd_ready !== 1'b1 && b < 2000) begin
      @(negedge clk);
      b++;
    end
    if (cmd_ready !== 1'b1) begin
      check("accept_timeout", 64'd0, 64'd1);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      tick_cnt = 0;
      tms_hist = '0;
      last_acc_cyc = cyc;
      if (expect_rsp) acc_q.push_back(cyc);
      if (!hold) cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 3000) begin
      @(negedge clk);
      b++;
    end
    if (exp_q.size() != 0) begin
      check("done_timeout", 64'd0, 64'd1);
      exp_q.delete(); tick_q.delete(); tms_q.delete(); acc_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int a1, b;
    #2 resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tck", tck, 0);
    check("rst_tms", tms, 1);
    check("rst_tdi", tdi, 0);
    check("rst_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_state", state_out, S_TLR);
    resetn = 1'b1;
    @(negedge clk);
    check("ready_after_rst", cmd_ready, 1);

    // TAP reset, IR load, IDCODE read
    issue(2'd0, 6'd6, 32'hFFFF_FFFF, 1, 0, 32'd0, 6, 64'b111110);
    wait_done();
    issue(2'd1, 6'd5, 32'h0000_0001, 1, 0, 32'h0000_0001, 11, TMS_IR5);
    wait_done();
    check("dap_ir_idcode", ir, IR_IDCODE);
    issue(2'd2, 6'd32, 32'd0, 1, 0, IDCODE, 37, TMS_DR32);
    wait_done();

    // BYPASS scans: len0 with held cmd_valid, clamp, partial length
    issue(2'd1, 6'd5, 32'h0000_001F, 1, 0, 32'h0000_0001, 11, TMS_IR5);
    wait_done();
    check("dap_ir_bypass", ir, 5'h1F);
    issue(2'd2, 6'd0, 32'hA5A5_0F0F, 1, 1, 32'h4B4A_1E1E, 37, TMS_DR32);
    repeat (3) begin
      @(negedge clk);
      check("held_ready", cmd_ready, 0);
      check("held_busy", busy, 1);
    end
    cmd_valid = 1'b0;
    wait_done();
    d = $urandom;
    issue(2'd2, 6'd40, d, 1, 0, {d[30:0], 1'b0}, 37, TMS_DR32);
    wait_done();
    d = $urandom;
    issue(2'd2, 6'd20, d, 1, 0, {d[30:0], 1'b0} & 32'h000F_FFFF, 25, TMS_DR20);
    wait_done();

    // async reset at shift tick 10 of a DR scan
    issue(2'd2, 6'd32, $urandom, 0, 0, 32'd0, 0, 64'd0);
    b = 0;
    while (tick_cnt < 14 && b < 1000) begin
      @(negedge clk);
      b++;
    end
    check("reach_tick10", tick_cnt, 14);
    #1 resetn = 1'b0;
    #1;
    check("mid_rst_tck", tck, 0);
    check("mid_rst_tms", tms, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_state", state_out, S_TLR);
    @(negedge clk);
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    issue(2'd3, 6'd2, $urandom, 1, 0, 32'd0, 3, 64'd0);
    wait_done();

    // back-to-back idle commands with cmd_valid held
    issue(2'd3, 6'd3, $urandom, 1, 1, 32'd0, 3, 64'd0);
    a1 = last_acc_cyc;
    issue(2'd3, 6'd1, $urandom, 1, 0, 32'd0, 1, 64'd0);
    check("b2b_accept", last_acc_cyc, last_rsp_cyc + 1);
    check("b2b_span", last_acc_cyc - a1, 4 * 3 + 1);
    wait_done();

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
